// File: rtl/latch_mon_pkg.sv
// Shared constants and state encoding for the latch_monitor block.
package latch_mon_pkg;

  localparam logic EVT_RISE = 1'b1;
  localparam logic EVT_FALL = 1'b0;

  localparam int unsigned CNT_W_DEF      = 8;
  localparam int unsigned FIFO_DEPTH_DEF = 4;
  localparam int unsigned TS_W_DEF       = 16;

  typedef enum logic {
    ARM = 1'b0,
    RUN = 1'b1
  } mon_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a valid/ready output side and a full flag.
// clr empties it and wins over any same-cycle push or pop.
module sync_fifo #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             full_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] data_o
);

  localparam int unsigned AW      = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             empty;
  logic             pop;
  logic             wr_en;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign valid_o = !empty;
  assign pop     = valid_o && ready_i && !clr_i;
  assign wr_en   = push_i && !clr_i && (!full_o || pop);
  assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (wr_en) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop)   rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/latch_monitor.sv
// Edge monitor for an asynchronous latch output: counts edges and queues events.
// Define LATCH_MON_TIMESTAMP_EN to add a free-running timestamp to each event.
module latch_monitor
  import latch_mon_pkg::*;
#(
  parameter int unsigned CNT_W      = CNT_W_DEF,
  parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int unsigned TS_W       = TS_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             q,
  input  logic             clr,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic             evt_kind,
`ifdef LATCH_MON_TIMESTAMP_EN
  output logic [TS_W-1:0]  evt_ts,
`endif
  output logic [CNT_W-1:0] rise_cnt,
  output logic [CNT_W-1:0] fall_cnt,
  output logic             overflow
);

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TS_W < 1 || CNT_W < 1)
  begin : g_param_check
    $error("latch_monitor: illegal parameter set");
  end

`ifdef LATCH_MON_TIMESTAMP_EN
  localparam int unsigned ENTRY_W = 1 + TS_W;
`else
  localparam int unsigned ENTRY_W = 1;
`endif

  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  logic             rst_sync_q;
  logic             s1_q, s2_q, s3_q;
  logic             edge_det;
  logic             edge_kind;
  mon_state_e       state_q, state_d;
  logic             arm_cnt_q, arm_cnt_d;
  logic             accept;
  logic             fifo_full;
  logic             handshake;
  logic [CNT_W-1:0] rise_cnt_q, rise_cnt_d;
  logic [CNT_W-1:0] fall_cnt_q, fall_cnt_d;
  logic             overflow_q, overflow_d;
  logic [ENTRY_W-1:0] push_data;
  logic [ENTRY_W-1:0] head_data;

  // Releases one edge after rst_n deasserts; ARM counting starts from there.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync_q <= 1'b0;
    else        rst_sync_q <= 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= q;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign edge_det  = s2_q ^ s3_q;
  assign edge_kind = s2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ARM;
      arm_cnt_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      arm_cnt_q <= arm_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    arm_cnt_d = arm_cnt_q;
    if (clr || !rst_sync_q) begin
      state_d   = ARM;
      arm_cnt_d = 1'b0;
    end else if (state_q == ARM) begin
      if (arm_cnt_q) state_d   = RUN;
      else           arm_cnt_d = 1'b1;
    end
  end

  assign accept    = (state_q == RUN) && edge_det && !clr;
  assign handshake = evt_valid && evt_ready;

  always_comb begin
    rise_cnt_d = rise_cnt_q;
    fall_cnt_d = fall_cnt_q;
    overflow_d = overflow_q;
    if (clr) begin
      rise_cnt_d = '0;
      fall_cnt_d = '0;
      overflow_d = 1'b0;
    end else if (accept) begin
      if (edge_kind == EVT_RISE) begin
        if (rise_cnt_q != '1) rise_cnt_d = rise_cnt_q + CNT_ONE;
      end else begin
        if (fall_cnt_q != '1) fall_cnt_d = fall_cnt_q + CNT_ONE;
      end
      // A pop in the same cycle frees the slot, so only a stalled full FIFO drops.
      if (fifo_full && !handshake) overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rise_cnt_q <= '0;
      fall_cnt_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      rise_cnt_q <= rise_cnt_d;
      fall_cnt_q <= fall_cnt_d;
      overflow_q <= overflow_d;
    end
  end

`ifdef LATCH_MON_TIMESTAMP_EN
  localparam logic [TS_W-1:0] TS_ONE = 1;
  logic [TS_W-1:0] ts_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ts_q <= '0;
    else        ts_q <= ts_q + TS_ONE;
  end

  assign push_data = {edge_kind, ts_q};
  assign evt_ts    = head_data[TS_W-1:0];
`else
  assign push_data = edge_kind;
`endif

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (clr),
    .push_i  (accept),
    .data_i  (push_data),
    .full_o  (fifo_full),
    .valid_o (evt_valid),
    .ready_i (evt_ready),
    .data_o  (head_data)
  );

  assign evt_kind = head_data[ENTRY_W-1];
  assign rise_cnt = rise_cnt_q;
  assign fall_cnt = fall_cnt_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_latch_monitor.sv
// Directed bench for latch_monitor; expected event kinds flow through a scoreboard queue.
module tb_latch_monitor;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       q;
  logic       clr;
  logic       evt_valid;
  logic       evt_ready;
  logic       evt_kind;
  logic [1:0] rise_cnt;
  logic [1:0] fall_cnt;
  logic       overflow;
`ifdef LATCH_MON_TIMESTAMP_EN
  logic [15:0] evt_ts;
`endif

  int   n_cmp = 0;
  int   n_err = 0;
  int   n_pop = 0;
  logic sb[$];

  always #5 clk = ~clk;

  latch_monitor #(
    .CNT_W      (2),
    .FIFO_DEPTH (4),
    .TS_W       (16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .q         (q),
    .clr       (clr),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_kind  (evt_kind),
`ifdef LATCH_MON_TIMESTAMP_EN
    .evt_ts    (evt_ts),
`endif
    .rise_cnt  (rise_cnt),
    .fall_cnt  (fall_cnt),
    .overflow  (overflow)
  );

  task automatic tick(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr_pulse();
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    sb.delete();
    tick(3);
  endtask

  // A handshake completes at the next rising edge unless clr overrides it.
  always @(negedge clk) begin
    logic exp_k;
    if (rst_n && evt_valid && evt_ready && !clr) begin
      n_pop++;
      n_cmp++;
      if (sb.size() == 0) begin
        n_err++;
        $error("FAIL pop_unexpected: observed kind=%0b expected no event", evt_kind);
      end else begin
        exp_k = sb.pop_front();
        assert (evt_kind === exp_k) else begin
          n_err++;
          $error("FAIL pop_kind: observed=%0b expected=%0b", evt_kind, exp_k);
        end
      end
    end
  end

  initial begin
    rst_n     = 1'b0;
    q         = 1'b1;
    clr       = 1'b0;
    evt_ready = 1'b1;

    // Reset values, with q already high to exercise ARM suppression.
    #22;
    check("rst_valid", evt_valid, 0);
    check("rst_rise", rise_cnt, 0);
    check("rst_fall", fall_cnt, 0);
    check("rst_ovf", overflow, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick(20);
    check("arm_rise", rise_cnt, 0);
    check("arm_valid", evt_valid, 0);
    check("arm_pops", n_pop, 0);

    // Single falling then single rising edge with the consumer always ready.
    q = 1'b0;
    sb.push_back(1'b0);
    tick(5);
    check("fall1_cnt", fall_cnt, 1);
    check("fall1_pops", n_pop, 1);
    clr_pulse();
    check("clr_rise", rise_cnt, 0);
    check("clr_fall", fall_cnt, 0);
    tick(17);
    q = 1'b1;
    sb.push_back(1'b1);
    tick(1);
    check("lat_n1_valid", evt_valid, 0);
    tick(1);
    check("lat_n2_valid", evt_valid, 0);
    tick(1);
    check("lat_n3_valid", evt_valid, 1);
    check("lat_n3_kind", evt_kind, 1);
    check("lat_n3_rise", rise_cnt, 1);
    tick(1);
    check("lat_n4_valid", evt_valid, 0);
    check("lat_pops", n_pop, 2);

    // Six edges into a stalled 4-deep FIFO: four held, two dropped but counted.
    clr_pulse();
    evt_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      q = ~q;
      if (i < 4) sb.push_back(q);
      tick(2);
    end
    tick(4);
    check("ovf_flag", overflow, 1);
    check("ovf_sum", 32'(rise_cnt) + 32'(fall_cnt), 6);
    check("ovf_valid", evt_valid, 1);
    check("ovf_head", evt_kind, 0);
    check("ovf_pops", n_pop, 2);

    // Full FIFO, new edge lands on the same edge as a handshake.
    clr_pulse();
    check("refill_ovf_clr", overflow, 0);
    for (int i = 0; i < 4; i++) begin
      q = ~q;
      sb.push_back(q);
      tick(2);
    end
    tick(3);
    check("full_ovf", overflow, 0);
    q = ~q;
    sb.push_back(q);
    tick(2);
    evt_ready = 1'b1;
    tick(1);
    evt_ready = 1'b0;
    check("pp_ovf", overflow, 0);
    check("pp_valid", evt_valid, 1);
    check("pp_head", evt_kind, 1);
    check("pp_pops", n_pop, 3);
    tick(3);
    check("pp_ovf_late", overflow, 0);
    evt_ready = 1'b1;
    tick(8);
    check("drain_valid", evt_valid, 0);
    check("drain_sb", sb.size(), 0);
    check("drain_pops", n_pop, 7);

    // Counter saturation at 2 bits.
    clr_pulse();
    for (int i = 0; i < 10; i++) begin
      q = ~q;
      sb.push_back(q);
      tick(3);
    end
    tick(4);
    check("sat_rise", rise_cnt, 3);
    check("sat_fall", fall_cnt, 3);
    check("sat_ovf", overflow, 0);
    check("sat_sb", sb.size(), 0);
    check("sat_pops", n_pop, 17);

    // clr together with an edge and a pending handshake.
    evt_ready = 1'b0;
    clr_pulse();
    q = 1'b1;
    sb.push_back(1'b1);
    tick(4);
    check("pend_valid", evt_valid, 1);
    check("pend_kind", evt_kind, 1);
    q = 1'b0;
    tick(2);
    clr       = 1'b1;
    evt_ready = 1'b1;
    tick(1);
    clr = 1'b0;
    sb.delete();
    check("cc_rise", rise_cnt, 0);
    check("cc_fall", fall_cnt, 0);
    check("cc_valid", evt_valid, 0);
    check("cc_ovf", overflow, 0);
    tick(6);
    check("cc_valid_late", evt_valid, 0);
    check("cc_fall_late", fall_cnt, 0);
    check("cc_pops", n_pop, 17);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/latch_monitor.md
LATCH_MONITOR -- requirements
Module: latch_monitor

Interface
REQ-001 The block SHALL have parameter CNT_W, default 8, giving the width of each edge counter.
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 4, giving event FIFO entries (power of two, >=2).
REQ-003 The block SHALL have parameter TS_W, default 16, giving the timestamp width.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 The block SHALL have port q, input, 1 bit: D-latch Q output, asynchronous to clk.
REQ-007 The block SHALL have port clr, input, 1 bit: synchronous clear of counters, FIFO and overflow.
REQ-008 The block SHALL have port evt_valid, output, 1 bit: the FIFO head is valid.
REQ-009 The block SHALL have port evt_ready, input, 1 bit: the consumer accepts the head.
REQ-010 The block SHALL have port evt_kind, output, 1 bit: 1 = rising edge of q, 0 = falling edge.
REQ-011 The block SHALL have port evt_ts, output, TS_W bits: timestamp of the event, present only with LATCH_MON_TIMESTAMP_EN.
REQ-012 The block SHALL have ports rise_cnt and fall_cnt, outputs, CNT_W bits each: edge counts.
REQ-013 The block SHALL have port overflow, output, 1 bit: sticky flag set when an event is dropped.

Function
REQ-014 The block SHALL sync q through two flops (s1, s2) and keep s3 = previous s2; edge = s2 XOR s3, kind = s2.
REQ-015 FSM states SHALL be ARM and RUN; reset and clr enter ARM; ARM lasts exactly 2 cycles, then RUN.
REQ-016 In ARM, detected edges SHALL be discarded, with no count and no push.
REQ-017 In RUN, q stable before clk edge N SHALL push the event at edge N+2; evt_valid SHALL be high after N+2 if the FIFO was empty.
REQ-018 Each accepted edge SHALL increment rise_cnt or fall_cnt; counters SHALL saturate at all-ones and never wrap.
REQ-019 A handshake SHALL occur when evt_valid && evt_ready at a clk edge; the head then pops.
REQ-020 When the FIFO is full and no pop occurs, the new event SHALL be dropped, counted anyway, and overflow SHALL be set.
REQ-021 A simultaneous push and pop on a full FIFO SHALL accept the push, leaving the FIFO full with no overflow.
REQ-022 A push and pop on an empty FIFO SHALL NOT bypass: evt_valid rises one cycle after the push edge.
REQ-023 evt_kind and evt_ts SHALL be stable while evt_valid is high and evt_ready is low.
REQ-024 clr SHALL take priority over any same-cycle edge or handshake: counters = 0, FIFO empty, overflow = 0, state ARM.
REQ-025 The timestamp counter SHALL free-run from 0 after reset, wrap modulo 2^TS_W, and be unaffected by clr.

Reset
REQ-026 On rst_n low, the following SHALL clear immediately: s1, s2, s3, counters, FIFO pointers, overflow and the timestamp counter; evt_valid = 0; state = ARM.
REQ-027 Reset deassertion SHALL be synchronized to clk; the first RUN cycle is the third clk edge after deassertion.

Configuration
REQ-028 Macro LATCH_MON_TIMESTAMP_EN defined: the FIFO entry SHALL be {kind, TS_W timestamp}, and evt_ts SHALL exist.
REQ-029 Macro LATCH_MON_TIMESTAMP_EN undefined: the entry SHALL be 1 bit, and neither evt_ts nor the timestamp counter SHALL exist.

Structure
REQ-030 Package latch_mon_pkg SHALL hold EVT_RISE = 1, EVT_FALL = 0, the ARM/RUN state encoding and parameter defaults.
REQ-031 The FIFO SHALL be sub-module sync_fifo (parameterized width/depth, valid/ready out, full flag); all other logic stays in latch_monitor.

Verification
REQ-032 Bench: toggle q 0->1 at t = 20 cycles with evt_ready = 1 -> one event, kind = 1, rise_cnt = 1, evt_valid high 1 cycle.
REQ-033 Bench: q = 1 throughout reset, then release -> no event and rise_cnt = 0 (ARM suppression).
REQ-034 Bench: evt_ready = 0, 6 edges with FIFO_DEPTH = 4 -> 4 events held, overflow = 1, rise_cnt + fall_cnt = 6.
REQ-035 Bench: FIFO full, edge arrives in the same cycle as a handshake -> no overflow, FIFO stays at 4 entries.
REQ-036 Bench: CNT_W = 2, 5 rising edges -> rise_cnt = 3 (saturated).
REQ-037 Bench: clr asserted in the same cycle as an edge and a pending handshake -> counters 0, evt_valid 0 next cycle, edge not recorded.
